// File: rtl/chunked_subtractor.sv
// Iterative N-bit subtractor: diff = a - b - bin, computed W bits per clock, LSB chunk first.
// Results are published only on the final chunk; intermediate work stays internal.
module chunked_subtractor #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);
    localparam int C  = N / W;
    localparam int IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg, idx_next;
    logic           borrow_reg, borrow_next;
    logic [N-1:0]   a_reg, a_next;
    logic [N-1:0]   b_reg, b_next;
    logic [N-1:0]   work_reg, work_next;
    logic [N-1:0]   diff_reg, diff_next;
    logic           bout_reg, bout_next;
    logic           ovf_reg, ovf_next;
    logic           done_reg, done_next;

    logic [W-1:0]   a_chunk [C];
    logic [W-1:0]   b_chunk [C];
    logic [W:0]     chunk_sum;
    logic [W-1:0]   chunk_res;
    logic           chunk_carry;
    logic [N-1:0]   merged;

    // Subtraction as a + ~b + carry-in, where carry-in is the inverted borrow.
    assign chunk_sum   = {1'b0, a_chunk[idx_reg]} + {1'b0, ~b_chunk[idx_reg]}
                       + {{W{1'b0}}, ~borrow_reg};
    assign chunk_res   = chunk_sum[W-1:0];
    assign chunk_carry = chunk_sum[W];

    generate
        for (genvar gi = 0; gi < C; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*W +: W];
            assign b_chunk[gi] = b_reg[gi*W +: W];
            // Work word with the chunk being processed this cycle already inserted.
            assign merged[gi*W +: W] = (int'(idx_reg) == gi) ? chunk_res : work_reg[gi*W +: W];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        borrow_next = borrow_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        work_next   = work_reg;
        diff_next   = diff_reg;
        bout_next   = bout_reg;
        ovf_next    = ovf_reg;
        done_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bin;
                    idx_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                work_next   = merged;
                borrow_next = ~chunk_carry;
                idx_next    = idx_reg + IW'(1);
                if (idx_reg == IW'(C - 1)) begin
                    diff_next  = merged;
                    bout_next  = ~chunk_carry;
                    ovf_next   = (a_reg[N-1] != b_reg[N-1]) && (merged[N-1] != a_reg[N-1]);
                    done_next  = 1'b1;
                    idx_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            borrow_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            work_reg   <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            borrow_reg <= borrow_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            work_reg   <= work_next;
            diff_reg   <= diff_next;
            bout_reg   <= bout_next;
            ovf_reg    <= ovf_next;
            done_reg   <= done_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
    assign ovf  = ovf_reg;
endmodule

// File: tb/tb_chunked_subtractor.sv
// Bench for chunked_subtractor: three configurations (16/4, 8/8, 12/3) checked every cycle
// against an arithmetic model, plus directed vectors with literal expected values.
module tb_chunked_subtractor;
    localparam int NI = 3;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    logic        start_v [NI];
    logic [15:0] a_v     [NI];
    logic [15:0] b_v     [NI];
    logic        bin_v   [NI];
    logic        busy_v  [NI];
    logic        done_v  [NI];
    logic        bout_v  [NI];
    logic        ovf_v   [NI];
    logic [15:0] diff_v  [NI];
    logic [15:0] d0;
    logic [7:0]  d1;
    logic [11:0] d2;

    // Model state: pending result and the cycles left until it is published.
    logic        m_busy [NI];
    logic        m_done [NI];
    int          m_cnt  [NI];
    logic [15:0] m_diff [NI];
    logic        m_bout [NI];
    logic        m_ovf  [NI];
    logic [15:0] p_diff [NI];
    logic        p_bout [NI];
    logic        p_ovf  [NI];

    function automatic int nn(input int i);
        return (i == 0) ? 16 : (i == 1) ? 8 : 12;
    endfunction

    function automatic int cc(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 4;
    endfunction

    function automatic void sub_model(input int n, input logic [15:0] a, input logic [15:0] b,
                                      input logic bin, output logic [15:0] d, output logic bo,
                                      output logic ov);
        longint mask, am, bm;
        mask = (longint'(1) << n) - 1;
        am   = longint'(a) & mask;
        bm   = longint'(b) & mask;
        d    = 16'((am - bm - longint'(bin)) & mask);
        bo   = (am < bm + longint'(bin));
        ov   = (a[n-1] != b[n-1]) && (d[n-1] != a[n-1]);
    endfunction

    task automatic check(input string name, input int i, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    chunked_subtractor #(.N(16), .W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .diff(d0), .bout(bout_v[0]), .ovf(ovf_v[0])
    );
    chunked_subtractor #(.N(8), .W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .bin(bin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .diff(d1), .bout(bout_v[1]),
        .ovf(ovf_v[1])
    );
    chunked_subtractor #(.N(12), .W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][11:0]), .b(b_v[2][11:0]),
        .bin(bin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .diff(d2), .bout(bout_v[2]),
        .ovf(ovf_v[2])
    );

    assign diff_v[0] = d0;
    assign diff_v[1] = {8'h00, d1};
    assign diff_v[2] = {4'h0, d2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] d;
        logic        bo;
        logic        ov;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_cnt[i]  <= 0;
                m_diff[i] <= '0;
                m_bout[i] <= 1'b0;
                m_ovf[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                m_done[i] <= 1'b0;
                if (m_busy[i]) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_diff[i] <= p_diff[i];
                        m_bout[i] <= p_bout[i];
                        m_ovf[i]  <= p_ovf[i];
                    end
                end else if (start_v[i]) begin
                    sub_model(nn(i), a_v[i], b_v[i], bin_v[i], d, bo, ov);
                    p_diff[i] <= d;
                    p_bout[i] <= bo;
                    p_ovf[i]  <= ov;
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= cc(i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                check("busy", i, 16'(busy_v[i]), 16'(m_busy[i]));
                check("done", i, 16'(done_v[i]), 16'(m_done[i]));
                check("diff", i, diff_v[i], m_diff[i]);
                check("bout", i, 16'(bout_v[i]), 16'(m_bout[i]));
                check("ovf", i, 16'(ovf_v[i]), 16'(m_ovf[i]));
            end
        end
    end

    task automatic wait_done(input int i, input int t0, input logic [15:0] ed, input logic eb,
                             input logic eo);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done_v[i]) seen = 1'b1;
        end
        check("done_seen", i, 16'(seen), 16'd1);
        if (seen) begin
            check("lit_latency", i, 16'(cyc - t0), 16'(cc(i)));
            check("lit_diff", i, diff_v[i], ed);
            check("lit_bout", i, 16'(bout_v[i]), 16'(eb));
            check("lit_ovf", i, 16'(ovf_v[i]), 16'(eo));
        end
    endtask

    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] ed, input logic eb, input logic eo);
        logic [15:0] md;
        logic        mb;
        logic        mo;
        int          t0;
        sub_model(nn(i), a, b, bin, md, mb, mo);
        check("model_diff", i, md, ed);
        check("model_bout", i, 16'(mb), 16'(eb));
        check("model_ovf", i, 16'(mo), 16'(eo));
        @(posedge clk); #1;
        a_v[i] = a; b_v[i] = b; bin_v[i] = bin; start_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        t0 = cyc;
        wait_done(i, t0, ed, eb, eo);
    endtask

    task automatic rand_ops(input int i, input int n);
        int hold;
        int gap;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            hold = $urandom_range(1, cc(i) + 2);
            gap  = $urandom_range(0, 2);
            start_v[i] = 1'b1;
            repeat (hold) begin
                a_v[i]   = 16'($urandom);
                b_v[i]   = 16'($urandom);
                bin_v[i] = 1'($urandom);
                @(posedge clk); #1;
            end
            start_v[i] = 1'b0;
            repeat (gap) @(posedge clk);
        end
        repeat (cc(i) + 3) @(posedge clk);
    endtask

    initial begin
        int t0;
        int ndone;
        bit seen;
        rst_n = 1'b0;
        cyc = 0; checks = 0; failures = 0;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; bin_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 0, 16'(busy_v[0]), 16'd0);
        check("rst_done", 0, 16'(done_v[0]), 16'd0);
        check("rst_diff", 0, diff_v[0], 16'h0000);
        check("rst_bout", 0, 16'(bout_v[0]), 16'd0);
        check("rst_ovf", 0, 16'(ovf_v[0]), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op(0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_op(0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_op(0, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op(1, 16'h0000, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0);
        run_op(1, 16'h0080, 16'h0001, 1'b0, 16'h007F, 1'b0, 1'b1);
        run_op(2, 16'h0800, 16'h0001, 1'b0, 16'h07FF, 1'b0, 1'b1);
        run_op(2, 16'h0123, 16'h0456, 1'b1, 16'h0CCC, 1'b1, 1'b0);

        // A second start while busy must not disturb the running operation.
        @(posedge clk); #1;
        a_v[0] = 16'h1234; b_v[0] = 16'h0234; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        t0 = cyc;
        @(posedge clk); #1;
        a_v[0] = 16'hFFFF; b_v[0] = 16'h0000; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, t0, 16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        check("single_pulse", 0, 16'(done_v[0]), 16'd0);
        check("idle_after", 0, 16'(busy_v[0]), 16'd0);

        // Reset mid-operation clears the held result at once.
        @(posedge clk); #1;
        a_v[0] = 16'h0000; b_v[0] = 16'h0001; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 0, 16'(busy_v[0]), 16'd0);
        check("arst_diff", 0, diff_v[0], 16'h0000);
        check("arst_done", 0, 16'(done_v[0]), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0]) seen = 1'b1;
        end
        check("no_done_after_rst", 0, 16'(seen), 16'd0);
        run_op(0, 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Start held high: one operation per C+1 cycles.
        @(posedge clk); #1;
        a_v[0] = 16'h4321; b_v[0] = 16'h0321; bin_v[0] = 1'b0; start_v[0] = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        start_v[0] = 1'b0;
        check("b2b_count", 0, 16'(ndone), 16'd2);
        check("b2b_diff", 0, diff_v[0], 16'h4000);
        repeat (6) @(posedge clk);

        fork
            rand_ops(0, 1000);
            rand_ops(1, 300);
            rand_ops(2, 300);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
